instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart to the core's opcode decoder. Accepts field-level instruction requests (class, funct3, funct7 bit 5, rd, rs1, rs2, immediate) over a valid/ready handshake.
- Assembles each request into a 32-bit RV32I word using the team's opcode map and immediate formats.
- Writes the words sequentially into instruction memory through its write port.
- Sits between the debug/test front-end and IMEM. Its purpose is to preload programs that the core then fetches and decodes.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit IMEM words writable; must be ≤ 2**ADDR_W.
- ADDR_W, 8, IMEM word-address width.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- arm_i  in  1  pulse: (re)start a load session at word address 0; priority over everything except rst_i.
- finish_i  in  1  end the session early (honoured only in ACCEPT with req_valid_i=0).
- req_valid_i  in  1  request valid.
- req_ready  out  1  block can accept a request this cycle.
- req_class_i  in  3  0=R, 1=I, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6=JALR, 7=LUI.
- req_funct3_i  in  3  funct3 field.
- req_funct7b5_i  in  1  instruction bit 30 (sub/sra/srai).
- req_rd_i, req_rs1_i, req_rs2_i  in  5 each  register indices.
- req_imm_i  in  32  byte-offset / immediate value, two's complement.
- imem_we  out  1  IMEM write strobe.
- imem_addr  out  ADDR_W  IMEM word address.
- imem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_W+1  words written this session.
- done  out  1  session closed (finish or full).
- full  out  1  IMEM_DEPTH words written.
- err  out  1  sticky: illegal immediate seen.

Behaviour:
- Reset values: state IDLE; req_ready, imem_we, done, full, err = 0; imem_addr, imem_wdata, word_count = 0.
- IDLE: req_ready=0. arm_i → ACCEPT, clearing addr, count, done, full and err.
- ACCEPT: req_ready=1.
  - req_valid_i & req_ready → capture all req_* fields, go to ENCODE. finish_i is ignored that cycle.
  - finish_i & !req_valid_i → DONE.
- ENCODE (1 cycle): register the encoded word into imem_wdata and run the legality check.
  - Legal → WRITE.
  - Illegal → ERROR.
- WRITE (1 cycle): imem_we=1 with imem_addr/imem_wdata stable. Next cycle: addr+1 and count+1.
  - If the written addr was IMEM_DEPTH-1, go to DONE with full=1.
  - Otherwise go to ACCEPT.
- DONE: done=1, req_ready=0. Holds until arm_i.
- ERROR: err=1, req_ready=0, no write. Holds until arm_i.
- Latency and throughput: handshake in cycle N → imem_we in cycle N+2. Maximum throughput is 1 word per 3 cycles.
- arm_i in any state returns to ACCEPT with the session cleared.
  - If arm_i is high during WRITE, imem_we is forced 0 that cycle and the in-flight word is dropped.
- Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
- Field placement: rd[11:7]; funct3[14:12]; rs1[19:15]; rs2[24:20].
  - rd is used by R, I, LOAD, JAL, JALR, LUI.
  - funct3 is used by all classes except JAL and LUI; JALR funct3 is forced to 000.
  - rs1 is used by all classes except JAL and LUI.
  - rs2 is used by R, STORE, BRANCH.
  - Unused fields are zero.
- R: bit30=funct7b5, other funct7 bits 0.
- I with funct3 001 or 101: [24:20]=imm[4:0], bit30=funct7b5, other bits of [31:25] 0.
- Other I, LOAD, JALR: [31:20]=imm[11:0].
- STORE: [31:25]=imm[11:5], [11:7]=imm[4:0].
- BRANCH: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- JAL: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- LUI: [31:12]=imm[31:12].
- Legality:
  - I (non-shift), LOAD, STORE, JALR: imm[31:11] all equal.
  - I shifts: imm[31:5]=0.
  - BRANCH: imm[31:12] all equal and imm[0]=0.
  - JAL: imm[31:20] all equal and imm[0]=0.
  - LUI: imm[11:0]=0.
  - R: always legal.
- Only class-specific field placement is performed; funct3 values are not checked.

Test Plan:
- arm; R x3,x1,x2, funct3=0, f7b5=0 → at accept+2 imem_we=1, imem_addr=0, imem_wdata=0x002081B3; word_count=1 after.
- Same with f7b5=1 (sub) → 0x402081B3 at addr 1. I x1,x0 imm=0xFFFFFFFF → 0xFFF00093 at addr 2.
- BRANCH rs1=1, rs2=2, funct3=0, imm=8 → 0x00208463. JAL rd=0 imm=-4 → 0xFFDFF06F. LUI rd=5 imm=0x12345000 → 0x123452B7.
- Illegal cases → err=1, req_ready=0, no imem_we: I imm=2048; BRANCH imm=3. A subsequent arm_i clears err and returns req_ready=1 next cycle.
- IMEM_DEPTH=4; stream 5 legal requests → writes at addr 0..3, then full=1, done=1, word_count=4, 5th request never acknowledged.
- arm_i asserted during WRITE → no imem_we that cycle, next cycle ACCEPT with addr 0, count 0. finish_i in idle ACCEPT → done=1, full=0, count unchanged.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Takes field-level RV32I instruction requests over a valid/ready handshake,
//   encodes each one into a 32-bit word, and writes the words to consecutive
//   IMEM addresses starting at 0.
//
//   state  | meaning
//   IDLE   | no session open, waiting for arm_i
//   ACCEPT | req_ready=1, waiting for a request or finish_i
//   ENCODE | captured request is encoded into imem_wdata and checked
//   WRITE  | imem_we=1 for one cycle, then addr/count advance
//   DONE   | session closed by finish_i or by filling IMEM
//   ERROR  | illegal immediate seen; nothing written, holds until arm_i
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   arm_i                  start or restart a session at word address 0
//   finish_i               close the session (ACCEPT with no valid request)
//   req_valid_i/req_ready  request handshake
//   req_class_i ... req_imm_i  instruction fields
//   imem_we/addr/wdata     IMEM write port
//   word_count, done, full, err  session status
module instr_encoder_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic              finish_i,
  input  logic              req_valid_i,
  output logic              req_ready,
  input  logic [2:0]        req_class_i,
  input  logic [2:0]        req_funct3_i,
  input  logic              req_funct7b5_i,
  input  logic [4:0]        req_rd_i,
  input  logic [4:0]        req_rs1_i,
  input  logic [4:0]        req_rs2_i,
  input  logic [31:0]       req_imm_i,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              full,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_ENCODE, S_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  state_t      state;
  logic        we_q;
  logic [2:0]  cls_q;
  logic [2:0]  f3_q;
  logic        f7b5_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [31:0] imm_q;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        is_shift;

  assign is_shift = (f3_q == 3'b001) || (f3_q == 3'b101);

  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (cls_q)
      3'd0: enc_word = {1'b0, f7b5_q, 5'd0, rs2_q, rs1_q, f3_q, rd_q, OP_R};
      3'd1: begin
        if (is_shift) begin
          enc_word  = {1'b0, f7b5_q, 5'd0, imm_q[4:0], rs1_q, f3_q, rd_q, OP_I};
          enc_legal = (imm_q[31:5] == 27'd0);
        end else begin
          enc_word  = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_I};
          enc_legal = (&imm_q[31:11]) || ~(|imm_q[31:11]);
        end
      end
      3'd2: begin
        enc_word  = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_LOAD};
        enc_legal = (&imm_q[31:11]) || ~(|imm_q[31:11]);
      end
      3'd3: begin
        enc_word  = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OP_STORE};
        enc_legal = (&imm_q[31:11]) || ~(|imm_q[31:11]);
      end
      3'd4: begin
        enc_word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                     imm_q[4:1], imm_q[11], OP_BRANCH};
        enc_legal = ((&imm_q[31:12]) || ~(|imm_q[31:12])) && !imm_q[0];
      end
      3'd5: begin
        enc_word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OP_JAL};
        enc_legal = ((&imm_q[31:20]) || ~(|imm_q[31:20])) && !imm_q[0];
      end
      3'd6: begin
        // JALR only has one valid funct3, so the requested one is ignored.
        enc_word  = {imm_q[11:0], rs1_q, 3'b000, rd_q, OP_JALR};
        enc_legal = (&imm_q[31:11]) || ~(|imm_q[31:11]);
      end
      default: begin
        enc_word  = {imm_q[31:12], rd_q, OP_LUI};
        enc_legal = (imm_q[11:0] == 12'd0);
      end
    endcase
  end

  // arm_i must kill a write in the same cycle, so the strobe is gated
  // combinationally rather than waiting for the register to clear.
  assign imem_we = we_q & ~arm_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      we_q       <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      word_count <= '0;
      done       <= 1'b0;
      full       <= 1'b0;
      err        <= 1'b0;
      cls_q      <= 3'd0;
      f3_q       <= 3'd0;
      f7b5_q     <= 1'b0;
      rd_q       <= 5'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      imm_q      <= 32'd0;
    end else if (arm_i) begin
      state      <= S_ACCEPT;
      req_ready  <= 1'b1;
      we_q       <= 1'b0;
      imem_addr  <= '0;
      word_count <= '0;
      done       <= 1'b0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_ACCEPT: begin
          if (req_valid_i) begin
            cls_q     <= req_class_i;
            f3_q      <= req_funct3_i;
            f7b5_q    <= req_funct7b5_i;
            rd_q      <= req_rd_i;
            rs1_q     <= req_rs1_i;
            rs2_q     <= req_rs2_i;
            imm_q     <= req_imm_i;
            req_ready <= 1'b0;
            state     <= S_ENCODE;
          end else if (finish_i) begin
            req_ready <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_ENCODE: begin
          imem_wdata <= enc_word;
          if (enc_legal) begin
            we_q  <= 1'b1;
            state <= S_WRITE;
          end else begin
            err   <= 1'b1;
            state <= S_ERROR;
          end
        end
        S_WRITE: begin
          we_q       <= 1'b0;
          imem_addr  <= imem_addr + ADDR_W'(1);
          word_count <= word_count + (ADDR_W + 1)'(1);
          if (imem_addr == LAST_ADDR) begin
            full  <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            req_ready <= 1'b1;
            state     <= S_ACCEPT;
          end
        end
        S_IDLE, S_DONE, S_ERROR: state <= state;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader with a 4-word IMEM so the full boundary is
// reachable quickly. Writes are checked against a queue of expected
// {addr, word} pairs pushed as each request is handed over.
module tb_instr_encoder_loader;

  logic        clk_i = 1'b0;
  logic        rst_i, arm_i, finish_i, req_valid_i, req_ready;
  logic [2:0]  req_class_i, req_funct3_i;
  logic        req_funct7b5_i;
  logic [4:0]  req_rd_i, req_rs1_i, req_rs2_i;
  logic [31:0] req_imm_i;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;
  logic        done, full, err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb_q[$];
  logic [7:0] exp_addr;

  typedef struct {
    string       name;
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
    logic        legal;
  } vec_t;
  vec_t vecs[15];

  always #5 clk_i = ~clk_i;

  instr_encoder_loader #(.IMEM_DEPTH(4), .ADDR_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .finish_i(finish_i),
    .req_valid_i(req_valid_i), .req_ready(req_ready),
    .req_class_i(req_class_i), .req_funct3_i(req_funct3_i),
    .req_funct7b5_i(req_funct7b5_i), .req_rd_i(req_rd_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_imm_i(req_imm_i),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .done(done), .full(full), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge clk_i) begin
    if (imem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {imem_addr, 24'd0}, 32'hFFFFFFFF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", {24'd0, imem_addr}, {24'd0, e.addr});
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic do_arm();
    @(negedge clk_i);
    arm_i = 1'b1;
    @(negedge clk_i);
    arm_i = 1'b0;
    exp_addr = 8'd0;
  endtask

  task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] word, input logic push);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (req_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    req_class_i = cls; req_funct3_i = f3; req_funct7b5_i = f7;
    req_rd_i = rd; req_rs1_i = rs1; req_rs2_i = rs2; req_imm_i = imm;
    req_valid_i = 1'b1;
    if (push) begin
      sb_q.push_back('{exp_addr, word});
      exp_addr = exp_addr + 8'd1;
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic settle();
    bit ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (req_ready === 1'b1 || err === 1'b1 || done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("settle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{"branch",    3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h00208463, 1'b1};
    vecs[1]  = '{"jal",       3'd5, 3'd3, 1'b0, 5'd0, 5'd7, 5'd9, 32'hFFFFFFFC, 32'hFFDFF06F, 1'b1};
    vecs[2]  = '{"lui",       3'd7, 3'd0, 1'b0, 5'd5, 5'd3, 5'd0, 32'h12345000, 32'h123452B7, 1'b1};
    vecs[3]  = '{"store",     3'd3, 3'd2, 1'b0, 5'd9, 5'd1, 5'd2, 32'hFFFFFFF8, 32'hFE20AC23, 1'b1};
    vecs[4]  = '{"load",      3'd2, 3'd2, 1'b0, 5'd5, 5'd2, 5'd7, 32'd16,       32'h01012283, 1'b1};
    vecs[5]  = '{"jalr",      3'd6, 3'd7, 1'b0, 5'd1, 5'd5, 5'd0, 32'd4,        32'h004280E7, 1'b1};
    vecs[6]  = '{"srai",      3'd1, 3'd5, 1'b1, 5'd3, 5'd4, 5'd0, 32'd7,        32'h40725193, 1'b1};
    vecs[7]  = '{"addi_min",  3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b1};
    vecs[8]  = '{"addi_max",  3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h000007FF, 32'h7FF00093, 1'b1};
    vecs[9]  = '{"r_imm_ign", 3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF, 32'h002081B3, 1'b1};
    vecs[10] = '{"ill_i2048", 3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,     32'd0,        1'b0};
    vecs[11] = '{"ill_br3",   3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,        32'd0,        1'b0};
    vecs[12] = '{"ill_lui",   3'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'd0,        1'b0};
    vecs[13] = '{"ill_slli",  3'd1, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32,       32'd0,        1'b0};
    vecs[14] = '{"ill_jal",   3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'd0,        1'b0};

    rst_i = 1'b1; arm_i = 1'b0; finish_i = 1'b0; req_valid_i = 1'b0;
    req_class_i = 3'd0; req_funct3_i = 3'd0; req_funct7b5_i = 1'b0;
    req_rd_i = 5'd0; req_rs1_i = 5'd0; req_rs2_i = 5'd0; req_imm_i = 32'd0;
    exp_addr = 8'd0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_we",    {31'd0, imem_we}, 32'd0);
    check("rst_flags", {29'd0, done, full, err}, 32'd0);
    check("rst_addr",  {24'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_count", {23'd0, word_count}, 32'd0);

    // Sequential session: R add, R sub, I addi with latency check on the first.
    do_arm();
    check("arm_ready", {31'd0, req_ready}, 32'd1);
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b1);
    @(negedge clk_i);
    check("lat_n1_we", {31'd0, imem_we}, 32'd0);
    @(negedge clk_i);
    check("lat_n2_we", {31'd0, imem_we}, 32'd1);
    @(negedge clk_i);
    check("count_1", {23'd0, word_count}, 32'd1);
    send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b1);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b1);
    settle();
    check("count_3", {23'd0, word_count}, 32'd3);
    check("addr_3", {24'd0, imem_addr}, 32'd3);

    // Table: one fresh session per vector.
    for (int v = 0; v < 15; v++) begin
      do_arm();
      check({vecs[v].name, "_arm_err"}, {31'd0, err}, 32'd0);
      check({vecs[v].name, "_arm_rdy"}, {31'd0, req_ready}, 32'd1);
      send(vecs[v].cls, vecs[v].f3, vecs[v].f7, vecs[v].rd, vecs[v].rs1,
           vecs[v].rs2, vecs[v].imm, vecs[v].word, vecs[v].legal);
      settle();
      check({vecs[v].name, "_err"},   {31'd0, err}, {31'd0, ~vecs[v].legal});
      check({vecs[v].name, "_ready"}, {31'd0, req_ready}, {31'd0, vecs[v].legal});
      check({vecs[v].name, "_count"}, {23'd0, word_count}, {31'd0, vecs[v].legal});
    end

    // Fill the 4-word IMEM; the fifth request must never be accepted.
    do_arm();
    for (int i = 1; i <= 4; i++)
      send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, i, (i << 20) | 32'h93, 1'b1);
    settle();
    check("full_full",  {31'd0, full}, 32'd1);
    check("full_done",  {31'd0, done}, 32'd1);
    check("full_count", {23'd0, word_count}, 32'd4);
    begin
      bit acked = 0;
      req_class_i = 3'd1; req_funct3_i = 3'd0; req_imm_i = 32'd5; req_valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk_i);
        if (req_ready !== 1'b0) acked = 1;
      end
      req_valid_i = 1'b0;
      check("full_5th_blocked", {31'd0, acked}, 32'd0);
    end

    // arm_i during WRITE drops the word and restarts the session.
    do_arm();
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b1);
    send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0);
    @(posedge clk_i);
    #1 arm_i = 1'b1;
    @(negedge clk_i);
    check("armwr_we", {31'd0, imem_we}, 32'd0);
    @(posedge clk_i);
    #1 arm_i = 1'b0;
    exp_addr = 8'd0;
    @(negedge clk_i);
    check("armwr_ready", {31'd0, req_ready}, 32'd1);
    check("armwr_addr",  {24'd0, imem_addr}, 32'd0);
    check("armwr_count", {23'd0, word_count}, 32'd0);

    // finish_i in an idle ACCEPT closes the session without filling.
    send(3'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b1);
    settle();
    @(negedge clk_i);
    finish_i = 1'b1;
    @(negedge clk_i);
    finish_i = 1'b0;
    check("fin_done",  {31'd0, done}, 32'd1);
    check("fin_full",  {31'd0, full}, 32'd0);
    check("fin_count", {23'd0, word_count}, 32'd1);
    check("fin_ready", {31'd0, req_ready}, 32'd0);

    repeat (4) @(negedge clk_i);
    check("sb_drain", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
